// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg: shared types and width defaults for the SRAM arbiter.
// SRAM_ARB_RR_EN (optional define) selects round-robin arbitration.
package sram_arb_pkg;

  localparam int unsigned ADDR_W     = 13;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned MASK_W     = 4;
  localparam int unsigned RD_LAT_DEF = 2;

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    WAIT,
    RESP
  } state_e;

  typedef enum logic {
    OWN_IF,
    OWN_D
  } owner_e;

endpackage

// File: rtl/sram_arb_pick.sv
// sram_arb_pick: grant logic for the fetch and data request ports.
// SRAM_ARB_RR_EN swaps fixed data priority for round-robin on a tie.
module sram_arb_pick
  import sram_arb_pkg::*;
(
  input  logic       if_valid_i,
  input  logic       d_valid_i,
  input  logic       idle_i,
`ifdef SRAM_ARB_RR_EN
  input  owner_e     last_grant_i,
`endif
  output logic [1:0] gnt_o
);

  // gnt_o[1] = data port, gnt_o[0] = fetch port
  always_comb begin
    gnt_o = 2'b00;
    if (idle_i) begin
      if (d_valid_i && if_valid_i) begin
`ifdef SRAM_ARB_RR_EN
        gnt_o = (last_grant_i == OWN_D) ? 2'b01 : 2'b10;
`else
        gnt_o = 2'b10;
`endif
      end else if (d_valid_i) begin
        gnt_o = 2'b10;
      end else if (if_valid_i) begin
        gnt_o = 2'b01;
      end
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one single-port SRAM between fetch and load/store.
// Define SRAM_ARB_RR_EN for round-robin instead of data-first priority.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ADDR_W,
  parameter int unsigned DATA_WIDTH = DATA_W,
  parameter int unsigned NUM_WMASKS = MASK_W,
  parameter int unsigned RD_LAT     = RD_LAT_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  if_req_valid,
  output logic                  if_req_ready,
  input  logic [ADDR_WIDTH-1:0] if_req_addr,
  output logic                  if_rsp_valid,
  output logic [DATA_WIDTH-1:0] if_rsp_data,
  input  logic                  d_req_valid,
  output logic                  d_req_ready,
  input  logic                  d_req_we,
  input  logic [NUM_WMASKS-1:0] d_req_wmask,
  input  logic [ADDR_WIDTH-1:0] d_req_addr,
  input  logic [DATA_WIDTH-1:0] d_req_wdata,
  output logic                  d_rsp_valid,
  output logic [DATA_WIDTH-1:0] d_rsp_data,
  output logic                  sram_csb,
  output logic                  sram_web,
  output logic [NUM_WMASKS-1:0] sram_wmask,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0] sram_din,
  input  logic [DATA_WIDTH-1:0] sram_dout,
  output logic                  busy
);

  localparam int unsigned CW =
    (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  state_e          state_q, state_d;
  owner_e          owner_q, owner_d;
  logic            we_q, we_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic                  csb_q, csb_d;
  logic                  web_q, web_d;
  logic [NUM_WMASKS-1:0] wmask_q, wmask_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] din_q, din_d;

  logic                  if_vld_q, if_vld_d;
  logic [DATA_WIDTH-1:0] if_dat_q, if_dat_d;
  logic                  d_vld_q, d_vld_d;
  logic [DATA_WIDTH-1:0] d_dat_q, d_dat_d;

  logic [1:0] gnt;
  logic       idle;
  logic       hs_d, hs_if;

  // Ready is held low while reset is asserted.
  assign idle = (state_q == IDLE) && rst_n;

`ifdef SRAM_ARB_RR_EN
  owner_e last_grant_q;

  // Remember who won the last handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= OWN_IF;
    end else if (hs_d || hs_if) begin
      last_grant_q <= owner_d;
    end
  end
`endif

  sram_arb_pick u_pick (
    .if_valid_i   (if_req_valid),
    .d_valid_i    (d_req_valid),
    .idle_i       (idle),
`ifdef SRAM_ARB_RR_EN
    .last_grant_i (last_grant_q),
`endif
    .gnt_o        (gnt)
  );

  assign d_req_ready  = gnt[1];
  assign if_req_ready = gnt[0];
  assign hs_d  = d_req_valid & gnt[1];
  assign hs_if = if_req_valid & gnt[0];

  // Next state; SRAM command regs load on handshake, else clear.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    we_d     = we_q;
    cnt_d    = cnt_q;
    csb_d    = 1'b0;
    web_d    = 1'b0;
    wmask_d  = '0;
    addr_d   = '0;
    din_d    = '0;
    if_vld_d = 1'b0;
    if_dat_d = if_dat_q;
    d_vld_d  = 1'b0;
    d_dat_d  = d_dat_q;
    unique case (state_q)
      IDLE: begin
        if (hs_d) begin
          owner_d = OWN_D;
          we_d    = d_req_we;
          csb_d   = 1'b1;
          web_d   = d_req_we;
          wmask_d = d_req_wmask;
          addr_d  = d_req_addr;
          din_d   = d_req_wdata;
          state_d = CMD;
        end else if (hs_if) begin
          owner_d = OWN_IF;
          we_d    = 1'b0;
          csb_d   = 1'b1;
          addr_d  = if_req_addr;
          state_d = CMD;
        end
      end
      CMD: begin
        if (we_q) begin
          state_d = RESP;
        end else begin
          cnt_d   = CW'(RD_LAT - 1);
          state_d = (RD_LAT == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = RESP;
        end
      end
      RESP: begin
        if (owner_q == OWN_D) begin
          d_vld_d = 1'b1;
          d_dat_d = we_q ? '0 : sram_dout;
        end else begin
          if_vld_d = 1'b1;
          if_dat_d = sram_dout;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, latched request and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      owner_q  <= OWN_IF;
      we_q     <= 1'b0;
      cnt_q    <= '0;
      csb_q    <= 1'b0;
      web_q    <= 1'b0;
      wmask_q  <= '0;
      addr_q   <= '0;
      din_q    <= '0;
      if_vld_q <= 1'b0;
      if_dat_q <= '0;
      d_vld_q  <= 1'b0;
      d_dat_q  <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      we_q     <= we_d;
      cnt_q    <= cnt_d;
      csb_q    <= csb_d;
      web_q    <= web_d;
      wmask_q  <= wmask_d;
      addr_q   <= addr_d;
      din_q    <= din_d;
      if_vld_q <= if_vld_d;
      if_dat_q <= if_dat_d;
      d_vld_q  <= d_vld_d;
      d_dat_q  <= d_dat_d;
    end
  end

  assign sram_csb     = csb_q;
  assign sram_web     = web_q;
  assign sram_wmask   = wmask_q;
  assign sram_addr    = addr_q;
  assign sram_din     = din_q;
  assign if_rsp_valid = if_vld_q;
  assign if_rsp_data  = if_dat_q;
  assign d_rsp_valid  = d_vld_q;
  assign d_rsp_data   = d_dat_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed bench for sram_arbiter with an SRAM model.
// Build with SRAM_ARB_RR_EN defined to check round-robin grants.
module tb_sram_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req_valid, if_req_ready;
  logic [12:0] if_req_addr;
  logic        if_rsp_valid;
  logic [31:0] if_rsp_data;
  logic        d_req_valid, d_req_ready, d_req_we;
  logic [3:0]  d_req_wmask;
  logic [12:0] d_req_addr;
  logic [31:0] d_req_wdata;
  logic        d_rsp_valid;
  logic [31:0] d_rsp_data;
  logic        sram_csb, sram_web;
  logic [3:0]  sram_wmask;
  logic [12:0] sram_addr;
  logic [31:0] sram_din, sram_dout;
  logic        busy;

  logic [119:0] outs;
  logic [31:0]  mem [0:8191];
  logic [31:0]  p1, p2;
  logic         preload;
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sram_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready),
    .if_req_addr(if_req_addr),
    .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready),
    .d_req_we(d_req_we), .d_req_wmask(d_req_wmask),
    .d_req_addr(d_req_addr), .d_req_wdata(d_req_wdata),
    .d_rsp_valid(d_rsp_valid), .d_rsp_data(d_rsp_data),
    .sram_csb(sram_csb), .sram_web(sram_web),
    .sram_wmask(sram_wmask), .sram_addr(sram_addr),
    .sram_din(sram_din), .sram_dout(sram_dout),
    .busy(busy)
  );

  assign outs = {if_req_ready, if_rsp_valid, if_rsp_data,
                 d_req_ready, d_rsp_valid, d_rsp_data,
                 sram_csb, sram_web, sram_wmask, sram_addr,
                 sram_din, busy};

  // SRAM model with two-cycle registered read data.
  always @(posedge clk) begin
    if (preload) begin
      mem[13'h0040] <= 32'hDEADBEEF;
      mem[13'h0100] <= 32'hAAAAAAAA;
      mem[13'h1FFF] <= 32'hCAFEF00D;
    end
    if (sram_csb && sram_web) begin
      for (int b = 0; b < 4; b++)
        if (sram_wmask[b])
          mem[sram_addr][8*b +: 8] <= sram_din[8*b +: 8];
    end
    p1 <= (sram_csb && !sram_web) ? mem[sram_addr] : 32'h0;
    p2 <= p1;
  end
  assign sram_dout = p2;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] exp_seq;
    int busy_n;
    int w;
    rst_n        = 1'b0;
    preload      = 1'b1;
    if_req_valid = 1'b1;
    if_req_addr  = 13'h0040;
    d_req_valid  = 1'b0;
    d_req_we     = 1'b0;
    d_req_wmask  = 4'h0;
    d_req_addr   = 13'h0;
    d_req_wdata  = 32'h0;

    // 1: reset with fetch valid held
    repeat (3) begin
      step();
      chk("rst_if_rdy", if_req_ready, 0);
    end
    chk("rst_outs", |outs, 0);
    preload = 1'b0;
    rst_n   = 1'b1;
    #1;
    chk("rel_if_rdy", if_req_ready, 1);
    chk("rel_d_rdy", d_req_ready, 0);

    // 2: fetch 0x040
    step();
    if_req_valid = 1'b0;
    busy_n = 0;
    for (int k = 0; k < 4; k++) begin
      chk("f_csb", sram_csb, (k == 0));
      chk("f_web", sram_web, 0);
      chk("f_rsp_v", if_rsp_valid, (k == 3));
      if (k == 0) chk("f_addr", sram_addr, 13'h0040);
      busy_n += int'(busy);
      if (k < 3) step();
    end
    chk("f_rsp_d", if_rsp_data, 32'hDEADBEEF);
    chk("f_busy_n", busy_n, 3);
    step();
    chk("f_pulse", if_rsp_valid, 0);

    // 3: store 0x100 mask 0011
    d_req_valid = 1'b1;
    d_req_we    = 1'b1;
    d_req_wmask = 4'b0011;
    d_req_addr  = 13'h0100;
    d_req_wdata = 32'h12345678;
    #1;
    chk("s_rdy", d_req_ready, 1);
    step();
    d_req_valid = 1'b0;
    d_req_we    = 1'b0;
    chk("s_csb", sram_csb, 1);
    chk("s_web", sram_web, 1);
    chk("s_mask", sram_wmask, 4'b0011);
    chk("s_din", sram_din, 32'h12345678);
    chk("s_addr", sram_addr, 13'h0100);
    step();
    chk("s_web_off", sram_web, 0);
    chk("s_rsp_early", d_rsp_valid, 0);
    step();
    chk("s_rsp_v", d_rsp_valid, 1);
    chk("s_rsp_d", d_rsp_data, 0);

    // load back the partially written word
    d_req_valid = 1'b1;
    d_req_addr  = 13'h0100;
    step();
    d_req_valid = 1'b0;
    repeat (3) step();
    chk("l_rsp_v", d_rsp_valid, 1);
    chk("l_rsp_d", d_rsp_data, 32'hAAAA5678);

    // 6: request while busy with a moving address
    if_req_valid = 1'b1;
    if_req_addr  = 13'h0040;
    step();
    if_req_valid = 1'b0;
    d_req_valid  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      d_req_addr = 13'h0200 + 13'(k);
      #1;
      chk("b_rdy", d_req_ready, 0);
      step();
    end
    chk("b_if_v", if_rsp_valid, 1);
    chk("b_if_d", if_rsp_data, 32'hDEADBEEF);
    d_req_addr = 13'h1FFF;
    #1;
    chk("b_rdy_idle", d_req_ready, 1);
    step();
    d_req_valid = 1'b0;
    chk("b_csb", sram_csb, 1);
    chk("b_addr", sram_addr, 13'h1FFF);
    repeat (3) step();
    chk("b_rsp_v", d_rsp_valid, 1);
    chk("b_rsp_d", d_rsp_data, 32'hCAFEF00D);

    // 5: reset during WAIT of a load
    d_req_valid = 1'b1;
    d_req_addr  = 13'h0040;
    step();
    d_req_valid = 1'b0;
    step();
    chk("r_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("r_outs", |outs, 0);
    repeat (3) begin
      step();
      chk("r_no_rsp", d_rsp_valid, 0);
    end
    rst_n = 1'b1;
    if_req_valid = 1'b1;
    if_req_addr  = 13'h0040;
    step();
    if_req_valid = 1'b0;
    repeat (3) step();
    chk("r_rsp_v", if_rsp_valid, 1);
    chk("r_rsp_d", if_rsp_data, 32'hDEADBEEF);
    chk("r_d_quiet", d_rsp_valid, 0);

    // 4: simultaneous fetch and load
`ifdef SRAM_ARB_RR_EN
    exp_seq = 4'b0101;
`else
    exp_seq = 4'b1111;
`endif
    d_req_valid  = 1'b1;
    d_req_addr   = 13'h0100;
    if_req_valid = 1'b1;
    if_req_addr  = 13'h0040;
    for (int t = 0; t < 4; t++) begin
      w = 0;
      #1;
      while (!(d_req_ready || if_req_ready) && w < 10) begin
        step();
        w++;
      end
      chk("g_wait", (w < 10), 1);
      chk("g_one", d_req_ready & if_req_ready, 0);
      chk("g_who", d_req_ready, exp_seq[t]);
      step();
    end
    d_req_valid  = 1'b0;
    if_req_valid = 1'b0;
    repeat (6) step();
    chk("g_idle", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
